// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int frame_bits(input int data_bits, input parity_t parity, input int stop_bits);
        return 32'sd1 + data_bits + ((parity == PAR_NONE) ? 32'sd0 : 32'sd1) + stop_bits;
    endfunction

    // Zero-extension of narrower words does not change the reduction result.
    function automatic logic parity_bit(input logic [8:0] data, input parity_t parity);
        logic result;
        case (parity)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~^data;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; rdata always presents the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-only UART fed from a small FIFO; frames stream back-to-back while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      CLOCK_HZ   = 48000000,
    parameter int      BAUD       = 9600,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            serial_tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int CPB = CLOCK_HZ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam int IW  = $clog2(DATA_BITS);

    if (CPB < 2) begin : g_bad_cpb
        $error("CLOCK_HZ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t            state_r, state_n;
    logic [TW-1:0]        timer_r, timer_n;
    logic [IW-1:0]        bit_idx_r, bit_idx_n;
    logic                 stop_idx_r, stop_idx_n;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic                 serial_r, serial_n;
    logic                 tick_s;
    logic                 load_s;
    logic                 shift_s;
    logic                 full_s;
    logic                 empty_s;
    logic [DATA_BITS-1:0] head_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_valid && tx_ready),
        .pop   (load_s),
        .wdata (tx_data),
        .rdata (head_s),
        .count (fifo_count),
        .full  (full_s),
        .empty (empty_s)
    );

    assign tick_s    = (timer_r == TW'(CPB - 1));
    assign tx_ready  = !full_s;
    assign serial_tx = serial_r;
    assign busy      = (state_r != ST_IDLE) || !empty_s;

    // Next-state, line level and FIFO pop decision.
    always_comb begin
        state_n    = state_r;
        bit_idx_n  = bit_idx_r;
        stop_idx_n = stop_idx_r;
        serial_n   = serial_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        if (state_r == ST_IDLE || tick_s) begin
            timer_n = {TW{1'b0}};
        end else begin
            timer_n = timer_r + TW'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    serial_n = 1'b1;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_n   = ST_DATA;
                    bit_idx_n = {IW{1'b0}};
                    serial_n  = shift_r[0];
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (!tick_s) begin
                    state_n = ST_DATA;
                end else if (bit_idx_r != IW'(DATA_BITS - 1)) begin
                    bit_idx_n = bit_idx_r + IW'(1);
                    shift_s   = 1'b1;
                    serial_n  = shift_r[1];
                end else if (PARITY != PAR_NONE) begin
                    state_n  = ST_PARITY;
                    serial_n = parity_r;
                end else begin
                    state_n    = ST_STOP;
                    stop_idx_n = 1'b0;
                    serial_n   = 1'b1;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_n    = ST_STOP;
                    stop_idx_n = 1'b0;
                    serial_n   = 1'b1;
                end else begin
                    state_n = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (!tick_s) begin
                    state_n = ST_STOP;
                end else if (stop_idx_r != 1'(STOP_BITS - 1)) begin
                    stop_idx_n = 1'b1;
                end else if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_n  = ST_IDLE;
                    serial_n = 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                serial_n = 1'b1;
            end
        endcase
        // A pop always opens a new frame with the start bit on the same edge.
        if (load_s) begin
            state_n  = ST_START;
            timer_n  = {TW{1'b0}};
            serial_n = 1'b0;
        end else begin
            state_n = state_n;
        end
    end

    // Control state, bit timer and registered line output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            timer_r    <= {TW{1'b0}};
            bit_idx_r  <= {IW{1'b0}};
            stop_idx_r <= 1'b0;
            serial_r   <= 1'b1;
        end else begin
            state_r    <= state_n;
            timer_r    <= timer_n;
            bit_idx_r  <= bit_idx_n;
            stop_idx_r <= stop_idx_n;
            serial_r   <= serial_n;
        end
    end

    // Payload shifter and parity captured from the popped word.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r  <= {DATA_BITS{1'b0}};
            parity_r <= 1'b0;
        end else if (load_s) begin
            shift_r  <= head_s;
            parity_r <= parity_bit(9'(head_s), PARITY);
        end else if (shift_s) begin
            shift_r  <= shift_r >> 1;
        end else begin
            shift_r  <= shift_r;
        end
    end

endmodule
